// File: rtl/data_mem_responder_if.sv
// Load/store port between the core's memory stage (master) and the data memory (slave).
// Request and response are independent valid/ready channels.
interface data_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [63:0] req_addr;
   logic [2:0]  req_size;
   logic [63:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_size, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_size, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle little-endian data memory: one request at a time, WAIT_CYCLES of latency,
// b/h/w/d loads and stores with sign/zero extension and misalign/range/size error reporting.
module data_mem_responder #(
   parameter int DEPTH_BYTES = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                clk,
   input  logic                reset,
   data_mem_responder_if.slave bus,
   output logic [63:0]         elem1,
   output logic [63:0]         elem2,
   output logic [63:0]         elem3
);

   localparam int AW  = $clog2(DEPTH_BYTES);
   localparam int AW1 = AW + 1;
   localparam int CW  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   state_t        state, next_state;
   logic [CW-1:0] count;
   logic          lat_write;
   logic [63:0]   lat_addr;
   logic [2:0]    lat_size;
   logic [63:0]   lat_wdata;
   logic [7:0]    mem [DEPTH_BYTES];
   logic [63:0]   rdata_q;
   logic          err_q;

   logic          accept, access, release_rsp;
   logic [3:0]    size_bytes;
   logic          size_ok, align_ok, range_ok, acc_err;
   logic [AW-1:0] base;
   logic [AW:0]   idx;
   logic [63:0]   raw, load_data;

   // The WAIT slot is always visited once, so the access edge lands at accept+1+WAIT_CYCLES.
   always_comb begin
      next_state    = state;
      bus.req_ready = 1'b0;
      accept        = 1'b0;
      access        = 1'b0;
      release_rsp   = 1'b0;
      case (state)
         ST_IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               accept     = 1'b1;
               next_state = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (count == '0) begin
               access     = 1'b1;
               next_state = ST_RESP;
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               release_rsp = 1'b1;
               next_state  = ST_IDLE;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Range check uses a 65-bit sum so huge addresses cannot wrap back into range.
   always_comb begin
      size_bytes = 4'd1 << lat_size[1:0];
      size_ok    = (lat_size != 3'b111) && !(lat_write && lat_size[2]);
      align_ok   = (lat_addr[2:0] & 3'(size_bytes - 4'd1)) == 3'b000;
      range_ok   = ({1'b0, lat_addr} + 65'(size_bytes)) <= 65'(DEPTH_BYTES);
      acc_err    = !(size_ok && align_ok && range_ok);
      base       = lat_addr[AW-1:0];
   end

   always_comb begin
      raw = '0;
      idx = '0;
      for (int i = 0; i < 8; i++) begin
         idx = {1'b0, base} + AW1'(i);
         if (idx < AW1'(DEPTH_BYTES)) raw[8*i +: 8] = mem[idx[AW-1:0]];
      end
   end

   always_comb begin
      case (lat_size)
         3'b000:  load_data = {{56{raw[7]}},  raw[7:0]};
         3'b001:  load_data = {{48{raw[15]}}, raw[15:0]};
         3'b010:  load_data = {{32{raw[31]}}, raw[31:0]};
         3'b011:  load_data = raw;
         3'b100:  load_data = {56'd0, raw[7:0]};
         3'b101:  load_data = {48'd0, raw[15:0]};
         3'b110:  load_data = {32'd0, raw[31:0]};
         default: load_data = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         count     <= '0;
         lat_write <= 1'b0;
         lat_addr  <= '0;
         lat_size  <= '0;
         lat_wdata <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         for (int i = 0; i < DEPTH_BYTES; i++) mem[i] <= 8'd0;
      end else begin
         state <= next_state;
         if (accept) begin
            lat_write <= bus.req_write;
            lat_addr  <= bus.req_addr;
            lat_size  <= bus.req_size;
            lat_wdata <= bus.req_wdata;
            count     <= CW'(WAIT_CYCLES);
         end else if (state == ST_WAIT && count != '0) begin
            count <= count - CW'(1);
         end
         if (access) begin
            err_q   <= acc_err;
            rdata_q <= (acc_err || lat_write) ? 64'd0 : load_data;
            if (!acc_err && lat_write) begin
               for (int i = 0; i < 8; i++)
                  if (4'(i) < size_bytes) mem[base + AW'(i)] <= lat_wdata[8*i +: 8];
            end
         end
         if (release_rsp) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
         end
      end
   end

   assign bus.rsp_valid = (state == ST_RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;

   always_comb begin
      elem1 = '0;
      elem2 = '0;
      elem3 = '0;
      for (int i = 0; i < 8; i++) begin
         elem1[8*i +: 8] = mem[AW'(i)];
         elem2[8*i +: 8] = mem[AW'(i + 8)];
         elem3[8*i +: 8] = mem[AW'(i + 16)];
      end
   end

endmodule
